// File: rtl/hwregs_bus_master.sv
// hwregs bus initiator: in-order request queue, tag-matched read tracker with timeout error completion.
// Build with HWREGS_MASTER_STATS_EN defined to get a saturating timeout counter on o_stat_timeouts.
module hwregs_bus_master #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_cpu_valid,
    output logic        o_cpu_ready,
    input  logic        i_cpu_write,
    input  logic [15:0] i_cpu_address,
    input  logic [3:0]  i_cpu_wmask,
    input  logic [31:0] i_cpu_wdata,
    input  logic [8:0]  i_cpu_tag,
    output logic        o_resp_valid,
    output logic [8:0]  o_resp_tag,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error,
    output logic        o_hwregs_request,
    output logic        o_hwregs_write,
    output logic [15:0] o_hwregs_address,
    output logic [3:0]  o_hwregs_wmask,
    output logic [31:0] o_hwregs_wdata,
    input  logic        i_hwregs_rvalid,
    input  logic [8:0]  i_hwregs_rtag,
    input  logic [31:0] i_hwregs_rdata,
    output logic [15:0] o_stat_timeouts
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = $clog2(TIMEOUT + 1);
    localparam int SW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef struct packed {
        logic        write;
        logic [15:0] address;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [8:0]  tag;
    } req_t;

    req_t               r_queue [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;
    logic [MAX_OUT-1:0] r_busy;
    logic [8:0]         r_slot_tag [MAX_OUT];
    logic [AW-1:0]      r_slot_age [MAX_OUT];

    logic          w_enq;
    logic          w_issue;
    req_t          w_head;
    logic          w_match_vld;
    logic [SW-1:0] w_match_idx;
    logic          w_to_vld;
    logic [SW-1:0] w_to_idx;
    logic          w_done_vld;
    logic          w_done_err;
    logic [SW-1:0] w_done_idx;
    logic          w_free_vld;
    logic [SW-1:0] w_free_idx;

    assign o_cpu_ready = (r_count != (PW+1)'(DEPTH));
    assign w_enq       = i_cpu_valid && o_cpu_ready;
    assign w_head      = r_queue[r_rd_ptr];

    // Descending scans so the lowest matching slot index wins.
    always_comb begin
        w_match_vld = 1'b0;
        w_match_idx = '0;
        w_to_vld    = 1'b0;
        w_to_idx    = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (i_hwregs_rvalid && r_busy[i] && (r_slot_tag[i] == i_hwregs_rtag)) begin
                w_match_vld = 1'b1;
                w_match_idx = SW'(i);
            end
            if (r_busy[i] && (r_slot_age[i] == AW'(TIMEOUT))) begin
                w_to_vld = 1'b1;
                w_to_idx = SW'(i);
            end
        end
    end

    // A real response beats a timeout; a saturated slot simply waits its turn.
    assign w_done_vld = w_match_vld || w_to_vld;
    assign w_done_err = !w_match_vld;
    assign w_done_idx = w_match_vld ? w_match_idx : w_to_idx;

    // The slot completing this cycle already counts as free for the issue decision.
    always_comb begin
        w_free_vld = 1'b0;
        w_free_idx = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!r_busy[i] || (w_done_vld && (w_done_idx == SW'(i)))) begin
                w_free_vld = 1'b1;
                w_free_idx = SW'(i);
            end
        end
    end

    assign w_issue = (r_count != '0) && (w_head.write || w_free_vld);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_busy           <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                r_slot_tag[i] <= '0;
                r_slot_age[i] <= '0;
            end
            o_hwregs_request <= 1'b0;
            o_hwregs_write   <= 1'b0;
            o_hwregs_address <= '0;
            o_hwregs_wmask   <= '0;
            o_hwregs_wdata   <= '0;
            o_resp_valid     <= 1'b0;
            o_resp_tag       <= '0;
            o_resp_rdata     <= '0;
            o_resp_error     <= 1'b0;
        end else begin
            if (w_enq) begin
                r_queue[r_wr_ptr] <= {i_cpu_write, i_cpu_address, i_cpu_wmask, i_cpu_wdata, i_cpu_tag};
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_issue);

            for (int i = 0; i < MAX_OUT; i++) begin
                if (r_busy[i] && (r_slot_age[i] != AW'(TIMEOUT))) begin
                    r_slot_age[i] <= r_slot_age[i] + AW'(1);
                end
                if (w_done_vld && (w_done_idx == SW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
                if (w_issue && !w_head.write && (w_free_idx == SW'(i))) begin
                    r_busy[i]     <= 1'b1;
                    r_slot_tag[i] <= w_head.tag;
                    r_slot_age[i] <= '0;
                end
            end

            o_hwregs_request <= w_issue;
            if (w_issue) begin
                o_hwregs_write   <= w_head.write;
                o_hwregs_address <= w_head.address;
                o_hwregs_wmask   <= w_head.write ? w_head.wmask : 4'hF;
                o_hwregs_wdata   <= w_head.write ? w_head.wdata : {23'b0, w_head.tag};
            end

            o_resp_valid <= w_done_vld;
            if (w_done_vld) begin
                o_resp_tag   <= r_slot_tag[w_done_idx];
                o_resp_rdata <= w_done_err ? 32'hFFFF_FFFF : i_hwregs_rdata;
                o_resp_error <= w_done_err;
            end
        end
    end

`ifdef HWREGS_MASTER_STATS_EN
    logic [15:0] r_stat_timeouts;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_stat_timeouts <= '0;
        end else if (w_done_vld && w_done_err && (r_stat_timeouts != 16'hFFFF)) begin
            r_stat_timeouts <= r_stat_timeouts + 16'd1;
        end
    end

    assign o_stat_timeouts = r_stat_timeouts;
`else
    assign o_stat_timeouts = 16'h0000;
`endif

endmodule

// File: tb/tb_hwregs_bus_master.sv
// Directed bench for hwregs_bus_master: per-cycle vector table plus timeout, backpressure and reset sequences.
module tb_hwregs_bus_master;

`ifdef HWREGS_MASTER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        cpu_write;
    logic [15:0] cpu_address;
    logic [3:0]  cpu_wmask;
    logic [31:0] cpu_wdata;
    logic [8:0]  cpu_tag;
    logic        resp_valid;
    logic [8:0]  resp_tag;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        hwregs_request;
    logic        hwregs_write;
    logic [15:0] hwregs_address;
    logic [3:0]  hwregs_wmask;
    logic [31:0] hwregs_wdata;
    logic        hwregs_rvalid;
    logic [8:0]  hwregs_rtag;
    logic [31:0] hwregs_rdata;
    logic [15:0] stat_timeouts;

    hwregs_bus_master #(.DEPTH(4), .MAX_OUT(2), .TIMEOUT(64)) dut (
        .i_clock(clock), .i_reset(reset),
        .i_cpu_valid(cpu_valid), .o_cpu_ready(cpu_ready), .i_cpu_write(cpu_write),
        .i_cpu_address(cpu_address), .i_cpu_wmask(cpu_wmask), .i_cpu_wdata(cpu_wdata), .i_cpu_tag(cpu_tag),
        .o_resp_valid(resp_valid), .o_resp_tag(resp_tag), .o_resp_rdata(resp_rdata), .o_resp_error(resp_error),
        .o_hwregs_request(hwregs_request), .o_hwregs_write(hwregs_write), .o_hwregs_address(hwregs_address),
        .o_hwregs_wmask(hwregs_wmask), .o_hwregs_wdata(hwregs_wdata),
        .i_hwregs_rvalid(hwregs_rvalid), .i_hwregs_rtag(hwregs_rtag), .i_hwregs_rdata(hwregs_rdata),
        .o_stat_timeouts(stat_timeouts)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, vld, wr;
        logic [15:0] addr;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic [8:0]  tag;
        logic        rvld;
        logic [8:0]  rtag;
        logic [31:0] rdata;
        logic        x_rdy, x_req, chk_bus, x_wr;
        logic [15:0] x_addr;
        logic [3:0]  x_wm;
        logic [31:0] x_wd;
        logic        x_rv, chk_resp;
        logic [8:0]  x_rtag;
        logic [31:0] x_rdata;
        logic        x_err;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    function automatic vec_t mkv(input logic rst, vld, wr, input logic [15:0] addr, input logic [3:0] wm,
                                 input logic [31:0] wd, input logic [8:0] tag, input logic rvld,
                                 input logic [8:0] rtag, input logic [31:0] rdata, input logic x_rdy, x_req,
                                 chk_bus, x_wr, input logic [15:0] x_addr, input logic [3:0] x_wm,
                                 input logic [31:0] x_wd, input logic x_rv, chk_resp, input logic [8:0] x_rtag,
                                 input logic [31:0] x_rdata, input logic x_err);
        return '{rst, vld, wr, addr, wm, wd, tag, rvld, rtag, rdata, x_rdy, x_req, chk_bus, x_wr,
                 x_addr, x_wm, x_wd, x_rv, chk_resp, x_rtag, x_rdata, x_err};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [15:0] addr, input logic [3:0] wm,
                             input logic [31:0] wd, input logic [8:0] tag);
        cpu_valid = 1'b1; cpu_write = wr; cpu_address = addr; cpu_wmask = wm; cpu_wdata = wd; cpu_tag = tag;
    endtask

    task automatic rsp(input logic [8:0] tag, input logic [31:0] data);
        hwregs_rvalid = 1'b1; hwregs_rtag = tag; hwregs_rdata = data;
    endtask

    task automatic idle();
        cpu_valid = 1'b0; hwregs_rvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic bad;
        logic flag;
        int   t0;

        reset = 1'b1; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wmask = '0;
        cpu_wdata = '0; cpu_tag = '0; hwregs_rvalid = 1'b0; hwregs_rtag = '0; hwregs_rdata = '0;

        // rst vld wr addr wm wd tag | rvld rtag rdata | rdy req chk_bus wr addr wm wd | rv chk_resp tag rdata err
        vq.push_back(mkv('1,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '0,'1,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'1,'1,16'h0004,4'h3,32'h3FF,9'h000, '0,9'h000,32'h0, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'1,'1,'1,16'h0004,4'h3,32'h3FF, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'0,'1,'1,16'h0004,4'h3,32'h3FF, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'1,'0,16'h0030,4'h0,32'h0,9'h005, '0,9'h000,32'h0, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'1,'1,'0,16'h0030,4'hF,32'h005, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'0,'1,'0,16'h0030,4'hF,32'h005, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '1,9'h005,32'h1234, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '1,'1,9'h005,32'h1234,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '1,9'h1FF,32'h5555, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'1,'1,16'h0008,4'hF,32'hAA,9'h000, '0,9'h000,32'h0, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'1,'0,16'h0010,4'h0,32'h0,9'h033, '0,9'h000,32'h0, '1,'1,'1,'1,16'h0008,4'hF,32'hAA, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'1,'1,'0,16'h0010,4'hF,32'h033, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '0,'0,9'h000,32'h0,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '1,9'h033,32'hDEADBEEF, '1,'0,'0,'0,16'h0000,4'h0,32'h0, '1,'1,9'h033,32'hDEADBEEF,'0));
        vq.push_back(mkv('0,'0,'0,16'h0000,4'h0,32'h0,9'h000, '0,9'h000,32'h0, '1,'0,'1,'0,16'h0010,4'hF,32'h033, '0,'0,9'h000,32'h0,'0));

        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            reset = v.rst; cpu_valid = v.vld; cpu_write = v.wr; cpu_address = v.addr; cpu_wmask = v.wm;
            cpu_wdata = v.wd; cpu_tag = v.tag; hwregs_rvalid = v.rvld; hwregs_rtag = v.rtag; hwregs_rdata = v.rdata;
            tick();
            bad = (cpu_ready !== v.x_rdy) || (hwregs_request !== v.x_req) || (resp_valid !== v.x_rv);
            if (v.chk_bus && ({hwregs_write, hwregs_address, hwregs_wmask, hwregs_wdata} !== {v.x_wr, v.x_addr, v.x_wm, v.x_wd}))
                bad = 1'b1;
            if (v.chk_resp && ({resp_tag, resp_rdata, resp_error} !== {v.x_rtag, v.x_rdata, v.x_err}))
                bad = 1'b1;
            n_vec++;
            if (bad) begin
                n_err++;
                $display("FAIL vec%0d: got rdy=%b req=%b bus=%b/%h/%h/%h rv=%b resp=%h/%h/%b, expected rdy=%b req=%b bus=%b/%h/%h/%h rv=%b resp=%h/%h/%b",
                         k, cpu_ready, hwregs_request, hwregs_write, hwregs_address, hwregs_wmask, hwregs_wdata,
                         resp_valid, resp_tag, resp_rdata, resp_error, v.x_rdy, v.x_req, v.x_wr, v.x_addr, v.x_wm,
                         v.x_wd, v.x_rv, v.x_rtag, v.x_rdata, v.x_err);
            end
        end
        idle();
        check("reset_stat", stat_timeouts, 0);

        // MAX_OUT stall and timeout of both in-flight reads
        drive_req(1'b0, 16'h0040, 4'h0, 32'h0, 9'h001); tick();
        drive_req(1'b0, 16'h0044, 4'h0, 32'h0, 9'h002); tick(); t0 = cyc;
        check("mo_req_t1", {hwregs_request, hwregs_wdata[8:0]}, {1'b1, 9'h001});
        drive_req(1'b0, 16'h0048, 4'h0, 32'h0, 9'h003); tick();
        check("mo_req_t2", {hwregs_request, hwregs_wdata[8:0]}, {1'b1, 9'h002});
        idle(); tick();
        check("mo_stall", hwregs_request, 0);
        flag = 1'b0;
        for (int k = 0; k < 200 && resp_valid !== 1'b1; k++) begin
            if (hwregs_request !== 1'b0) flag = 1'b1;
            tick();
        end
        check("mo_quiet", flag, 0);
        check("mo_to_lat", cyc - t0, 65);
        check("mo_to_t1", {resp_valid, resp_error, resp_tag, resp_rdata}, {1'b1, 1'b1, 9'h001, 32'hFFFFFFFF});
        check("mo_issue_t3", {hwregs_request, hwregs_write, hwregs_wdata[8:0]}, {1'b1, 1'b0, 9'h003});
        tick();
        check("mo_to_t2", {resp_valid, resp_error, resp_tag, resp_rdata}, {1'b1, 1'b1, 9'h002, 32'hFFFFFFFF});
        rsp(9'h003, 32'h0000_0333); tick(); idle();
        check("mo_rsp_t3", {resp_valid, resp_error, resp_tag, resp_rdata}, {1'b1, 1'b0, 9'h003, 32'h0000_0333});

        // Queue fills behind a stalled read; a fifth request waits for a dequeue
        drive_req(1'b0, 16'h0050, 4'h0, 32'h0, 9'h010); tick();
        drive_req(1'b0, 16'h0054, 4'h0, 32'h0, 9'h011); tick(); t0 = cyc;
        drive_req(1'b0, 16'h0058, 4'h0, 32'h0, 9'h012); tick();
        drive_req(1'b1, 16'h0100, 4'hF, 32'h1111_0000, 9'h000); tick();
        drive_req(1'b1, 16'h0104, 4'hF, 32'h1111_0001, 9'h000); tick();
        drive_req(1'b1, 16'h0108, 4'hF, 32'h1111_0002, 9'h000); tick();
        check("full_ready", cpu_ready, 0);
        drive_req(1'b1, 16'h010C, 4'hF, 32'h1111_0003, 9'h000);
        flag = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (resp_valid === 1'b1) break;
            if (cpu_ready !== 1'b0) flag = 1'b1;
        end
        check("full_hold", flag, 0);
        check("full_to_lat", cyc - t0, 65);
        check("full_to_t10", {resp_valid, resp_error, resp_tag}, {1'b1, 1'b1, 9'h010});
        check("full_issue_t12", {hwregs_request, hwregs_write, hwregs_wdata[8:0]}, {1'b1, 1'b0, 9'h012});
        check("full_ready_back", cpu_ready, 1);
        tick(); idle();
        check("full_to_t11", {resp_valid, resp_error, resp_tag}, {1'b1, 1'b1, 9'h011});
        check("st_order0", {hwregs_request, hwregs_write, hwregs_address, hwregs_wdata}, {1'b1, 1'b1, 16'h0100, 32'h1111_0000});
        for (int j = 1; j < 4; j++) begin
            tick();
            check($sformatf("st_order%0d", j), {hwregs_request, hwregs_write, hwregs_address, hwregs_wdata},
                  {1'b1, 1'b1, 16'h0100 + 16'(4 * j), 32'h1111_0000 + 32'(j)});
        end
        tick();
        check("st_no_dup", hwregs_request, 0);
        rsp(9'h012, 32'h0000_ABCD); tick(); idle();
        check("full_rsp_t12", {resp_valid, resp_error, resp_tag, resp_rdata}, {1'b1, 1'b0, 9'h012, 32'h0000_ABCD});

        // Real response and a timeout due together; then stray and late responses
        drive_req(1'b0, 16'h0060, 4'h0, 32'h0, 9'h008); tick();
        drive_req(1'b0, 16'h0064, 4'h0, 32'h0, 9'h007); tick(); t0 = cyc; idle();
        check("arb_req_t8", {hwregs_request, hwregs_wdata[8:0]}, {1'b1, 9'h008});
        tick();
        check("arb_req_t7", {hwregs_request, hwregs_wdata[8:0]}, {1'b1, 9'h007});
        flag = 1'b0;
        while ((cyc - t0) < 64) begin
            tick();
            if (resp_valid !== 1'b0) flag = 1'b1;
        end
        check("arb_quiet", flag, 0);
        rsp(9'h007, 32'h0000_7777); tick();
        check("arb_real_first", {resp_valid, resp_error, resp_tag, resp_rdata}, {1'b1, 1'b0, 9'h007, 32'h0000_7777});
        rsp(9'h1FF, 32'h5A5A_5A5A); tick();
        check("arb_to_next", {resp_valid, resp_error, resp_tag, resp_rdata}, {1'b1, 1'b1, 9'h008, 32'hFFFFFFFF});
        rsp(9'h1FF, 32'h5A5A_5A5A); tick();
        check("stray_drop", resp_valid, 0);
        rsp(9'h008, 32'h0000_8888); tick(); idle();
        check("late_drop", resp_valid, 0);
        check("stat_cnt", stat_timeouts, STATS_EN ? 64'd5 : 64'd0);

        // Reset with two reads in flight
        drive_req(1'b0, 16'h0070, 4'h0, 32'h0, 9'h020); tick();
        drive_req(1'b0, 16'h0074, 4'h0, 32'h0, 9'h021); tick(); idle(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_ready", cpu_ready, 1);
        check("rst_outputs", {hwregs_request, resp_valid, resp_error, resp_tag, resp_rdata}, 0);
        check("rst_stat", stat_timeouts, 0);
        rsp(9'h020, 32'h0000_CAFE); tick();
        check("rst_drop0", resp_valid, 0);
        rsp(9'h021, 32'h0000_BEEF); tick(); idle();
        check("rst_drop1", resp_valid, 0);
        flag = 1'b0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (resp_valid !== 1'b0 || hwregs_request !== 1'b0) flag = 1'b1;
        end
        check("rst_no_timeout", flag, 0);
        check("rst_stat_end", stat_timeouts, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hwregs_bus_master.md
Name: hwregs_bus_master

Overview:
Initiator for the hardware-register bus at 0xE0000000. It accepts CPU load/store requests through a valid/ready queue and drives the hwregs request/write/address/wmask/wdata signals. Read responses are matched by tag and returned to the CPU. Any read not answered within a timeout is completed with an error, so a missing responder cannot hang the pipeline.

Parameters:
DEPTH, 4, request queue entries (power of 2, >=2)
MAX_OUT, 2, maximum reads in flight on the hwregs bus (1..4)
TIMEOUT, 64, cycles a read may remain unanswered before error completion

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_valid  in  1  CPU request present
cpu_ready  out  1  queue can accept (not full)
cpu_write  in  1  1=store, 0=load
cpu_address  in  16  register offset within 64kB block
cpu_wmask  in  4  byte enables for store
cpu_wdata  in  32  store data
cpu_tag  in  9  load tag, returned with response
resp_valid  out  1  one-cycle pulse, load complete
resp_tag  out  9  tag of completed load
resp_rdata  out  32  load data (0xFFFFFFFF on error)
resp_error  out  1  1=completed by timeout
hwregs_request  out  1  bus request strobe
hwregs_write  out  1  1=write
hwregs_address  out  16  bus address
hwregs_wmask  out  4  bus byte enables
hwregs_wdata  out  32  store data; for reads {23'b0, tag}
hwregs_rvalid  in  1  responder read data valid
hwregs_rtag  in  9  responder tag
hwregs_rdata  in  32  responder data
stat_timeouts  out  16  timeout count (optional feature)

Behaviour:
- Reset: queue empty, no reads in flight. cpu_ready=1, hwregs_request=0, resp_valid=0, resp_error=0, resp_tag=0, resp_rdata=0, stat_timeouts=0. Reset mid-operation discards all queued and in-flight requests; a response arriving after reset is dropped.
- Enqueue: on cpu_valid && cpu_ready. cpu_ready = !full. Enqueue and issue in the same cycle on a full queue are allowed: the dequeue frees the slot, but cpu_ready stays registered-low for that cycle.
- Issue: at most one request per cycle, strictly in queue order, no write/read reordering.
  - Head is a write: issue unconditionally. The bus cycle is 1 clock: outputs registered, hwregs_request=1 for exactly one cycle. No response is expected.
  - Head is a read: issue only if in-flight count < MAX_OUT. Otherwise the head stalls, blocking younger writes.
  - hwregs_wmask is forced to 4'hF for reads. When hwregs_request=0, all other bus outputs hold their last values.
- Tracker: MAX_OUT slots, each {busy, tag, age counter}. A slot is allocated on read issue with age=0. Age increments each cycle while busy and saturates at TIMEOUT.
- Response: on hwregs_rvalid, look up the busy slot whose tag == hwregs_rtag (lowest index wins on duplicates).
  - Match: the next cycle gives resp_valid=1, resp_tag, resp_rdata=hwregs_rdata, resp_error=0. The slot is freed.
  - No match (late or stray): dropped, no resp_valid.
- Timeout: a slot with age==TIMEOUT completes next cycle with resp_valid=1, resp_error=1, resp_rdata=0xFFFFFFFF. The slot is freed.
- Arbitration: if a real response and a timeout are due in the same cycle, the real response wins. The timed-out slot stays saturated and completes on the next free cycle. With multiple timeouts, the lowest slot index goes first.
- A freed slot is reusable on the same cycle's issue decision.
- Nominal latency: enqueue to hwregs_request is 1 cycle when the queue is empty. The hwregs responder answers 1 cycle after the request, and resp_valid follows 1 cycle later, so load-to-resp is 3 cycles.
- The tag is opaque. Duplicate in-flight tags are legal, but the CPU is responsible for uniqueness if ordering matters.

Optional Feature:
HWREGS_MASTER_STATS_EN
- Defined: stat_timeouts increments on every error completion, saturating at 0xFFFF, and clears on reset.
- Undefined: stat_timeouts is tied to 0 and no counter logic is built.

Test Plan:
- Store addr 0x0004, wdata 0x3FF, mask 4'h3 -> one-cycle hwregs_request with write=1, address 0x0004, wmask 3; no resp_valid.
- Load addr 0x0030, tag 0x05; responder returns rtag 0x05, rdata 0x1234 -> resp_valid 3 cycles after enqueue with tag 0x05, rdata 0x1234, error=0; hwregs_wdata[8:0]=0x05 during the request.
- MAX_OUT=2, three back-to-back loads (tags 1,2,3) with the responder silent -> only two requests issued, third stalls; at age 64 tag 1 then tag 2 complete with error=1, rdata 0xFFFFFFFF; tag 3 then issues.
- Fill queue with 4 stores while MAX_OUT reads are blocked -> cpu_ready=0; a fifth request is not accepted until an entry dequeues.
- Real response for tag 7 in the same cycle tag 8 reaches timeout -> tag 7 resp first (error=0), tag 8 error resp on the next cycle; stray rtag 0x1FF produces no resp.
- Assert reset with 2 reads in flight, then drive responder rvalid -> no resp_valid, cpu_ready=1, stat_timeouts=0.
